// File: rtl/display_arbiter_if.sv
// Display-sharing bus between the two requesters, the idle source and the
// arbiter that drives the 7-segment display interface.
interface display_arbiter_if;
  logic [15:0] idleVal;
  logic        reqA;
  logic [15:0] valA;
  logic        reqB;
  logic [15:0] valB;
  logic [15:0] dispVal;
  logic        grantA;
  logic        grantB;
  logic        busy;

  // Requester/background side: drives requests and values, sees grants.
  modport master (
    output idleVal, reqA, valA, reqB, valB,
    input  dispVal, grantA, grantB, busy
  );

  // Arbiter side.
  modport slave (
    input  idleVal, reqA, valA, reqB, valB,
    output dispVal, grantA, grantB, busy
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 16-bit display value between requesters
// A and B, falling back to the idle value when nobody owns the display.
// A granted value is latched and held for DWELL cycles before the next
// arbitration decision.
module display_arbiter #(
  parameter int unsigned DWELL = 5000000
) (
  input  logic            clk5,
  input  logic            reset,
  display_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  // Last dwell cycle; the decision in a SHOW state happens on this count.
  localparam logic [23:0] DWELL_LAST = 24'(DWELL - 1);

  state_t      state_reg, state_next;
  logic [23:0] count_reg, count_next;
  logic        last_b_reg, last_b_next;
  logic [15:0] disp_reg, disp_next;
  logic        grant_a_reg, grant_a_next;
  logic        grant_b_reg, grant_b_next;

  logic decide;
  logic take_a;
  logic take_b;

  // State, dwell counter, pointer and registered outputs.
  always_ff @(posedge clk5) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= 24'd0;
      last_b_reg  <= 1'b1;  // A wins the first tie after reset
      disp_reg    <= 16'h0000;
      grant_a_reg <= 1'b0;
      grant_b_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      last_b_reg  <= last_b_next;
      disp_reg    <= disp_next;
      grant_a_reg <= grant_a_next;
      grant_b_reg <= grant_b_next;
    end
  end

  // Arbitration decision and next-state / next-output selection.
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    last_b_next  = last_b_reg;
    disp_next    = disp_reg;
    grant_a_next = 1'b0;
    grant_b_next = 1'b0;

    // Requests only matter at decision points: every IDLE cycle, or the
    // final dwell cycle of a SHOW state.
    decide = (state_reg == IDLE) || (count_reg == DWELL_LAST);
    // On a tie the pointer favours whoever was not granted last.
    take_a = decide && bus.reqA && (!bus.reqB || last_b_reg);
    take_b = decide && bus.reqB && (!bus.reqA || !last_b_reg);

    if (take_a) begin
      state_next   = SHOW_A;
      count_next   = 24'd0;
      last_b_next  = 1'b0;
      disp_next    = bus.valA;
      grant_a_next = 1'b1;
    end else if (take_b) begin
      state_next   = SHOW_B;
      count_next   = 24'd0;
      last_b_next  = 1'b1;
      disp_next    = bus.valB;
      grant_b_next = 1'b1;
    end else if (decide) begin
      // Nobody wants the display: track the background value.
      state_next = IDLE;
      count_next = 24'd0;
      disp_next  = bus.idleVal;
    end else begin
      // Mid-dwell: hold the latched value and keep counting.
      count_next = count_reg + 24'd1;
    end
  end

  assign bus.dispVal = disp_reg;
  assign bus.grantA  = grant_a_reg;
  assign bus.grantB  = grant_b_reg;
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized and directed bench for display_arbiter (DWELL = 4) checked
// against a behavioural owner/elapsed-time model of the arbitration rules.
module tb_display_arbiter;

  localparam int DW = 4;

  logic clk5 = 1'b0;
  logic reset;

  display_arbiter_if dif ();

  display_arbiter #(.DWELL(DW)) dut (
    .clk5  (clk5),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #100 clk5 = ~clk5;

  int checks_total  = 0;
  int checks_passed = 0;

  // Behavioural model: who owns the display and for how many cycles.
  int          m_owner;    // 0 none, 1 A, 2 B
  int          m_elapsed;  // cycles the current value has been shown
  bit          m_last_b;
  logic [15:0] m_disp;
  bit          m_ga, m_gb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Advance one clock: update the model from the inputs held across the
  // edge, then compare all outputs shortly after the edge.
  task automatic step();
    int pick;
    @(posedge clk5);
    if (reset) begin
      m_owner = 0; m_elapsed = 0; m_last_b = 1'b1;
      m_disp = 16'h0000; m_ga = 1'b0; m_gb = 1'b0;
    end else begin
      m_ga = 1'b0; m_gb = 1'b0;
      if (m_owner == 0 || m_elapsed == DW) begin
        pick = 0;
        if (dif.reqA && dif.reqB) pick = m_last_b ? 1 : 2;
        else if (dif.reqA)        pick = 1;
        else if (dif.reqB)        pick = 2;
        m_owner   = pick;
        m_elapsed = (pick != 0) ? 1 : 0;
        if (pick == 1) begin
          m_disp = dif.valA; m_ga = 1'b1; m_last_b = 1'b0;
          $display("grant A val=%h t=%0t", dif.valA, $time);
        end else if (pick == 2) begin
          m_disp = dif.valB; m_gb = 1'b1; m_last_b = 1'b1;
          $display("grant B val=%h t=%0t", dif.valB, $time);
        end else begin
          m_disp = dif.idleVal;
        end
      end else begin
        m_elapsed++;
      end
    end
    #1;
    check_val("dispVal", 32'(dif.dispVal), 32'(m_disp));
    check_val("grantA",  32'(dif.grantA),  32'(m_ga));
    check_val("grantB",  32'(dif.grantB),  32'(m_gb));
    check_val("busy",    32'(dif.busy),    32'(m_owner != 0));
    check_val("grant_excl", 32'(dif.grantA & dif.grantB), 32'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    dif.idleVal = 16'h1234;
    dif.reqA = 1'b0; dif.valA = 16'h0000;
    dif.reqB = 1'b0; dif.valB = 16'h0000;

    // Reset with idle value present.
    steps(3);
    check_val("rst_disp", 32'(dif.dispVal), 32'h0000);
    reset = 1'b0;
    step();
    check_val("idle_track", 32'(dif.dispVal), 32'h1234);
    steps(2);

    // Single grant to A, request dropped after the grant.
    dif.reqA = 1'b1; dif.valA = 16'hAAAA;
    step();
    check_val("a_grant", 32'(dif.grantA), 32'd1);
    dif.reqA = 1'b0;
    steps(3);
    check_val("a_hold", 32'(dif.dispVal), 32'hAAAA);
    step();
    check_val("a_expire", 32'(dif.dispVal), 32'h1234);
    steps(2);

    // Both held: alternating A, B, A, B with no gap.
    dif.reqA = 1'b1; dif.valA = 16'hAAAA;
    dif.reqB = 1'b1; dif.valB = 16'hBBBB;
    steps(20);
    dif.reqA = 1'b0; dif.reqB = 1'b0;
    steps(6);

    // Value and idle changes during SHOW_A are ignored.
    dif.reqA = 1'b1; dif.valA = 16'hC0DE;
    step();
    dif.reqA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dif.valA = 16'($urandom); dif.idleVal = 16'($urandom);
      step();
      check_val("show_latched", 32'(dif.dispVal), 32'hC0DE);
    end
    steps(3);

    // A alone held: re-granted every DWELL cycles.
    dif.reqA = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dif.valA = 16'($urandom);
      step();
    end
    dif.reqA = 1'b0;
    steps(5);

    // Reset in the middle of SHOW_B with A pending.
    dif.reqB = 1'b1; dif.valB = 16'hBEEF;
    step();
    dif.reqB = 1'b0; dif.reqA = 1'b1; dif.valA = 16'h5A5A;
    steps(2);
    reset = 1'b1;
    step();
    check_val("midrst_disp", 32'(dif.dispVal), 32'h0000);
    check_val("midrst_busy", 32'(dif.busy), 32'd0);
    reset = 1'b0;
    step();
    check_val("post_rst_grantA", 32'(dif.grantA), 32'd1);
    dif.reqA = 1'b0;
    steps(5);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      dif.reqA    = ($urandom_range(0, 2) != 0);
      dif.reqB    = ($urandom_range(0, 2) == 0);
      dif.valA    = 16'($urandom);
      dif.valB    = 16'($urandom);
      dif.idleVal = 16'($urandom);
      reset       = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 16-bit display value of the 7-segment display interface between two requesting blocks and a background (idle) source. A requester raises a request with its value; the arbiter grants it, latches the value and holds it on the display for a fixed dwell time. It then either switches to a pending requester, round-robin, or falls back to the idle value. Sits directly upstream of the display interface and drives its `dispVal` input; runs in the same 5 MHz domain.

## Interface
- `DWELL`, default 5000000: cycles a granted value is held (1 s at 5 MHz). Legal range 2 .. 2^24-1.
- `clk5`  input  1  system clock, 5 MHz; all logic on rising edge.
- `reset`  input  1  synchronous, active-high; sampled on rising edge of `clk5`.
- `idleVal`  input  16  background value shown when no requester owns the display.
- `reqA`  input  1  requester A wants the display (level).
- `valA`  input  16  value from requester A; sampled only at the grant edge.
- `reqB`  input  1  requester B wants the display (level).
- `valB`  input  16  value from requester B; sampled only at the grant edge.
- `dispVal`  output  16  registered value to the display interface.
- `grantA`  output  1  one-cycle pulse: A's value accepted.
- `grantB`  output  1  one-cycle pulse: B's value accepted.
- `busy`  output  1  high while a requester owns the display (state SHOW_A or SHOW_B).

## Operation
- States: IDLE, SHOW_A, SHOW_B.
- Dwell counter: 24 bits; cleared on entry to SHOW_x; increments each cycle in SHOW_x.
- Round-robin pointer `lastB`: 1 bit; set to 1 on grant to B, cleared on grant to A.
- Decision point:
  - In IDLE: every cycle.
  - In SHOW_x: only the cycle with counter == DWELL-1.
- Decision rules, evaluated on request levels at the decision edge:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant B if `lastB`==0, otherwise grant A.
  - Neither requesting: go to IDLE, or stay in IDLE.
- The same requester may be re-granted back-to-back if it alone is requesting at expiry.
- Grant to x at an edge:
  - `dispVal` <= valx.
  - state <= SHOW_x.
  - counter <= 0.
  - grantx <= 1 for exactly one cycle.
  - Pointer is updated.
- In IDLE with no grant: `dispVal` <= `idleVal` each cycle.
- In SHOW_x: `dispVal` holds the latched value; `valA`/`valB`/`idleVal` changes are ignored.
- Requester protocol: hold req until grant seen high; deassert by the edge after grant if no further value is pending. Requests are never sampled outside decision points, so DWELL>=2 guarantees no double grant.
- `grantA` and `grantB` are never high in the same cycle.
- Reset values: state IDLE, `dispVal` 16'h0000, `grantA`=`grantB`=0, `busy`=0, counter 0, `lastB`=1 (A favoured on first tie).
- Reset mid-operation: display ownership is dropped immediately, with no grant pulse. Pending requests are re-arbitrated from IDLE after reset deasserts.

## Timing
- Request to grant, from IDLE: reqx sampled high at edge N; `grantx`=1 and `dispVal`=valx(N) from edge N through N+1. Latency is 1 cycle.
- Show duration: exactly DWELL cycles from grant edge to the next decision edge.
- Back-to-back handover: new value appears at the edge immediately following the last dwell cycle. There is no idle gap.
- Idle tracking: `dispVal` follows `idleVal` with 1-cycle latency while in IDLE and not granting.
- `busy` is high from the grant edge until the edge returning to IDLE. It is a registered state decode.
- After reset deasserts at edge R, the first possible grant is at edge R+1.

## Test plan
All scenarios use DWELL=4.
- Reset, then idleVal=16'h1234, no requests -> `dispVal`=16'h0000 during reset, 16'h1234 one cycle after release; `busy`=0, no grants.
- reqA=1 with valA=16'hAAAA for one grant, then dropped -> `grantA` one-cycle pulse; `dispVal`=16'hAAAA for exactly 4 cycles; then idleVal; `busy` high those 4 cycles.
- reqA and reqB both held high continuously, valA=16'hAAAA, valB=16'hBBBB -> A granted first, then B, A, B…. Each shows 4 cycles with no idle gap; grants alternate and never overlap.
- During SHOW_A change valA and idleVal every cycle -> `dispVal` stays at the latched value until expiry.
- reqA held, reqB never -> A re-granted every 4 cycles; `grantA` pulses every 4th cycle.
- Assert reset mid-SHOW_B (counter=2) with reqA high -> `dispVal`=0, `busy`=0 during reset; A granted one edge after release.
